// File: rtl/pc_flow_ctrl_pkg.sv
// pc_flow_ctrl_pkg: NPC operation encodings and PC flow FSM state encodings.
package pc_flow_ctrl_pkg;
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;
  typedef enum logic [1:0] {
    PCF_RUN  = 2'd0,
    PCF_WAIT = 2'd1,
    PCF_PEND = 2'd2
  } pcf_state_t;
endpackage

// File: rtl/pc_flow_ctrl_perf.sv
// pc_flow_ctrl_perf: saturating stall/redirect/wait cycle counters.
module pc_flow_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_ev,
  input  logic             redir_ev,
  input  logic             wait_ev,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] wait_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
      wait_cnt     <= '0;
    end else begin
      if (stall_ev && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (redir_ev && !(&redirect_cnt)) redirect_cnt <= redirect_cnt + 1'b1;
      if (wait_ev && !(&wait_cnt)) wait_cnt <= wait_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: next-PC sequencing and pipeline stall/flush control.
// Define PC_FLOW_PERF_CNT_EN to add saturating performance counters.
module pc_flow_ctrl
  import pc_flow_ctrl_pkg::*;
#(
  parameter int XLEN = 32
`ifdef PC_FLOW_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_branch,
  input  logic            mem_zero,
  input  logic            mem_jal,
  input  logic            mem_jalr,
  input  logic            id_load_use,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] npc_in,
  output logic [2:0]      npc_op,
  output logic            pc_we,
  output logic            pc_src_pend,
  output logic [XLEN-1:0] pc_pend,
  output logic            j_fetch,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic            busy
`ifdef PC_FLOW_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] redirect_cnt
  , output logic [CNT_W-1:0] wait_cnt
`endif
);
  pcf_state_t state, nxt;
  logic redirect, pend_ld;
  assign redirect = mem_valid & (mem_jal | mem_jalr | (mem_branch & mem_zero));
  assign busy = !rst && state != PCF_RUN;
  always_comb
    npc_op = (state == PCF_PEND || !mem_valid) ? NPC_PLUS4 :
             mem_jalr ? NPC_JALR : mem_jal ? NPC_JUMP : mem_branch ? NPC_BRANCH : NPC_PLUS4;
  always_comb begin
    nxt          = state;
    pend_ld      = 1'b0;
    pc_we        = 1'b0;
    pc_src_pend  = 1'b0;
    j_fetch      = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      case (state)
        PCF_RUN: begin
          if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pc_we        = imem_ready;
            pend_ld      = !imem_ready;
            nxt          = imem_ready ? PCF_RUN : PCF_PEND;
          end else if (id_load_use) begin
            j_fetch     = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            j_fetch     = 1'b1;
            if_id_flush = 1'b1;
            nxt         = PCF_WAIT;
          end else pc_we = 1'b1;
        end
        PCF_WAIT: begin
          j_fetch = 1'b1;
          if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pend_ld      = 1'b1;
            nxt          = PCF_PEND;
          end else begin
            if_id_stall = id_load_use;
            if_id_flush = !id_load_use;
            id_ex_flush = id_load_use;
            pc_we       = imem_ready;
            nxt         = imem_ready ? PCF_RUN : PCF_WAIT;
          end
        end
        default: begin
          pc_src_pend = 1'b1;
          if_id_flush = 1'b1;
          pc_we       = imem_ready;
          nxt         = imem_ready ? PCF_RUN : PCF_PEND;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PCF_RUN;
      pc_pend <= '0;
    end else begin
      state <= nxt;
      if (pend_ld) pc_pend <= npc_in;
    end
  end
`ifdef PC_FLOW_PERF_CNT_EN
  logic stall_ev, redir_ev, wait_ev;
  assign stall_ev = !rst && !redirect && id_load_use && state != PCF_PEND;
  assign redir_ev = !rst && redirect && state != PCF_PEND;
  assign wait_ev  = !rst && state != PCF_RUN;
  pc_flow_perf #(.CNT_W(CNT_W)) u_perf (
    .clk(clk), .rst(rst), .stall_ev(stall_ev), .redir_ev(redir_ev), .wait_ev(wait_ev),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt), .wait_cnt(wait_cnt)
  );
`endif
endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb_pc_flow_ctrl: directed self-checking bench for pc_flow_ctrl.
module tb_pc_flow_ctrl;
  import pc_flow_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_valid = 0, mem_branch = 0, mem_zero = 0, mem_jal = 0, mem_jalr = 0;
  logic id_load_use = 0, imem_ready = 1;
  logic [31:0] npc_in = '0, pc_pend;
  logic [2:0] npc_op;
  logic pc_we, pc_src_pend, j_fetch, if_id_stall, if_id_flush, id_ex_flush, ex_mem_flush, busy;
  int checks = 0, failures = 0;
`ifdef PC_FLOW_PERF_CNT_EN
  logic [3:0] stall_cnt, redirect_cnt, wait_cnt;
`endif

  pc_flow_ctrl #(
    .XLEN(32)
`ifdef PC_FLOW_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_jal(mem_jal), .mem_jalr(mem_jalr), .id_load_use(id_load_use), .imem_ready(imem_ready),
    .npc_in(npc_in), .npc_op(npc_op), .pc_we(pc_we), .pc_src_pend(pc_src_pend), .pc_pend(pc_pend),
    .j_fetch(j_fetch), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .busy(busy)
`ifdef PC_FLOW_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt), .wait_cnt(wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    mem_valid = 0; mem_branch = 0; mem_zero = 0; mem_jal = 0; mem_jalr = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_mem(); id_load_use = 0; imem_ready = 1;
    tick(); tick();
    checks++;
    if ({pc_we, if_id_flush, id_ex_flush, ex_mem_flush, if_id_stall, j_fetch, pc_src_pend, busy} !== 8'b0111_0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=01110000",
               {pc_we, if_id_flush, id_ex_flush, ex_mem_flush, if_id_stall, j_fetch, pc_src_pend, busy});
    end
    checks++;
    if (pc_pend !== 32'h0) begin failures++; $display("FAIL reset_pc_pend got=%h want=0", pc_pend); end
    rst = 0; #1;
    checks++;
    if ({pc_we, npc_op, busy, if_id_flush, id_ex_flush, ex_mem_flush} !== {1'b1, NPC_PLUS4, 4'b0}) begin
      failures++;
      $display("FAIL run_plus4 got we=%b op=%b busy=%b fl=%b%b%b", pc_we, npc_op, busy, if_id_flush, id_ex_flush, ex_mem_flush);
    end
  endtask

  task automatic test_branch();
    mem_valid = 1; mem_branch = 1; mem_zero = 1; imem_ready = 1; #1;
    checks++;
    if ({npc_op, pc_we, if_id_flush, id_ex_flush, ex_mem_flush} !== {NPC_BRANCH, 4'b1111}) begin
      failures++;
      $display("FAIL branch_taken got op=%b we=%b fl=%b%b%b", npc_op, pc_we, if_id_flush, id_ex_flush, ex_mem_flush);
    end
    tick(); clear_mem(); #1;
    checks++;
    if ({if_id_flush, id_ex_flush, ex_mem_flush, busy} !== 4'b0) begin
      failures++;
      $display("FAIL branch_one_cycle got fl=%b%b%b busy=%b want 0", if_id_flush, id_ex_flush, ex_mem_flush, busy);
    end
    mem_valid = 1; mem_branch = 1; mem_zero = 0; #1;
    checks++;
    if ({npc_op, pc_we, if_id_flush, id_ex_flush, ex_mem_flush} !== {NPC_BRANCH, 4'b1000}) begin
      failures++;
      $display("FAIL branch_not_taken got op=%b we=%b fl=%b%b%b", npc_op, pc_we, if_id_flush, id_ex_flush, ex_mem_flush);
    end
    tick(); clear_mem();
  endtask

  task automatic test_jalr_pend();
    mem_valid = 1; mem_jalr = 1; imem_ready = 0; npc_in = 32'h40; #1;
    checks++;
    if ({npc_op, pc_we, if_id_flush, id_ex_flush, ex_mem_flush} !== {NPC_JALR, 4'b0111}) begin
      failures++;
      $display("FAIL jalr_not_ready got op=%b we=%b fl=%b%b%b", npc_op, pc_we, if_id_flush, id_ex_flush, ex_mem_flush);
    end
    tick();
    clear_mem(); mem_valid = 1; mem_jal = 1; npc_in = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({busy, pc_src_pend, pc_we, if_id_flush, npc_op, pc_pend} !== {4'b1101, NPC_PLUS4, 32'h40}) begin
        failures++;
        $display("FAIL pend_hold[%0d] got busy=%b src=%b we=%b iff=%b op=%b pend=%h", i, busy, pc_src_pend, pc_we, if_id_flush, npc_op, pc_pend);
      end
      tick();
    end
    clear_mem(); imem_ready = 1; #1;
    checks++;
    if ({pc_we, pc_src_pend} !== 2'b11) begin failures++; $display("FAIL pend_release got we=%b src=%b want 11", pc_we, pc_src_pend); end
    tick();
    checks++;
    if ({busy, pc_src_pend, pc_we} !== 3'b001) begin failures++; $display("FAIL pend_to_run got busy=%b src=%b we=%b want 001", busy, pc_src_pend, pc_we); end
  endtask

  task automatic test_load_use();
    imem_ready = 1; id_load_use = 1; #1;
    checks++;
    if ({pc_we, j_fetch, if_id_stall, id_ex_flush, if_id_flush, ex_mem_flush, busy} !== 7'b0111000) begin
      failures++;
      $display("FAIL load_use got we=%b jf=%b st=%b idf=%b iff=%b exf=%b busy=%b want 0111000",
               pc_we, j_fetch, if_id_stall, id_ex_flush, if_id_flush, ex_mem_flush, busy);
    end
    tick(); id_load_use = 0; #1;
    checks++;
    if ({pc_we, j_fetch, if_id_stall, id_ex_flush, npc_op} !== {4'b1000, NPC_PLUS4}) begin
      failures++;
      $display("FAIL load_use_after got we=%b jf=%b st=%b idf=%b op=%b", pc_we, j_fetch, if_id_stall, id_ex_flush, npc_op);
    end
    imem_ready = 0; id_load_use = 1; #1;
    checks++;
    if ({pc_we, j_fetch, if_id_stall, if_id_flush} !== 4'b0110) begin
      failures++;
      $display("FAIL load_use_not_ready got we=%b jf=%b st=%b iff=%b want 0110", pc_we, j_fetch, if_id_stall, if_id_flush);
    end
    tick(); id_load_use = 0; imem_ready = 1; #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL load_use_stays_run got busy=%b want 0", busy); end
  endtask

  task automatic test_wait_redirect();
    imem_ready = 0; #1;
    checks++;
    if ({pc_we, j_fetch, if_id_flush, busy} !== 4'b0110) begin
      failures++;
      $display("FAIL enter_wait got we=%b jf=%b iff=%b busy=%b want 0110", pc_we, j_fetch, if_id_flush, busy);
    end
    tick();
    id_load_use = 1; #1;
    checks++;
    if ({busy, pc_we, j_fetch, if_id_stall, if_id_flush, id_ex_flush} !== 6'b101101) begin
      failures++;
      $display("FAIL wait_load_use got busy=%b we=%b jf=%b st=%b iff=%b idf=%b want 101101",
               busy, pc_we, j_fetch, if_id_stall, if_id_flush, id_ex_flush);
    end
    tick(); id_load_use = 0;
    mem_valid = 1; mem_jal = 1; npc_in = 32'h0000_1234; #1;
    checks++;
    if ({pc_we, if_id_flush, id_ex_flush, ex_mem_flush, npc_op} !== {4'b0111, NPC_JUMP}) begin
      failures++;
      $display("FAIL wait_redirect got we=%b fl=%b%b%b op=%b", pc_we, if_id_flush, id_ex_flush, ex_mem_flush, npc_op);
    end
    tick(); clear_mem();
    checks++;
    if ({busy, pc_src_pend, pc_pend} !== {2'b11, 32'h1234}) begin
      failures++;
      $display("FAIL wait_to_pend got busy=%b src=%b pend=%h want 1 1 00001234", busy, pc_src_pend, pc_pend);
    end
    imem_ready = 1; tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL wait_pend_exit got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    imem_ready = 1; id_load_use = 1; mem_valid = 1; mem_jal = 1; #1;
    checks++;
    if ({pc_we, if_id_stall, j_fetch, if_id_flush, id_ex_flush, ex_mem_flush, npc_op} !== {6'b100111, NPC_JUMP}) begin
      failures++;
      $display("FAIL redirect_beats_load_use got we=%b st=%b jf=%b fl=%b%b%b op=%b",
               pc_we, if_id_stall, j_fetch, if_id_flush, id_ex_flush, ex_mem_flush, npc_op);
    end
    tick(); id_load_use = 0; mem_jalr = 1; mem_branch = 1; #1;
    checks++;
    if (npc_op !== NPC_JALR) begin failures++; $display("FAIL jalr_priority got op=%b want %b", npc_op, NPC_JALR); end
    mem_valid = 0; #1;
    checks++;
    if ({npc_op, if_id_flush} !== {NPC_PLUS4, 1'b0}) begin
      failures++;
      $display("FAIL invalid_mem got op=%b iff=%b", npc_op, if_id_flush);
    end
    tick(); clear_mem();
  endtask

`ifdef PC_FLOW_PERF_CNT_EN
  task automatic test_perf();
    rst = 1; clear_mem(); id_load_use = 0; imem_ready = 1; tick(); rst = 0;
    checks++;
    if ({stall_cnt, redirect_cnt, wait_cnt} !== 12'h0) begin failures++; $display("FAIL perf_reset got %h want 000", {stall_cnt, redirect_cnt, wait_cnt}); end
    id_load_use = 1;
    for (int i = 0; i < 20; i++) tick();
    id_load_use = 0;
    checks++;
    if ({stall_cnt, redirect_cnt, wait_cnt} !== 12'hf00) begin failures++; $display("FAIL perf_stall_sat got %h want f00", {stall_cnt, redirect_cnt, wait_cnt}); end
  endtask
`endif

  initial begin
    test_reset();
    test_branch();
    test_jalr_pend();
    test_load_use();
    test_wait_redirect();
    test_back_to_back();
`ifdef PC_FLOW_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
- Sequences the next-PC datapath and the pipeline registers around it.
- Takes redirect requests from the MEM stage (taken branch, jal, jalr), load-use stalls from ID, and instruction-memory ready.
- Produces NPC operation select, PC write enable, refetch control (j_fetch), and per-stage stall/flush controls.
- Holds a redirect target in a pending register when fetch cannot accept it in the same cycle.

Parameters:
- XLEN, 32, PC/target width.
- CNT_W, 32, performance counter width (used only with PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a live instruction.
- mem_branch  in  1  MEM instruction is a conditional branch.
- mem_zero  in  1  branch condition true.
- mem_jal  in  1  MEM instruction is jal.
- mem_jalr  in  1  MEM instruction is jalr.
- id_load_use  in  1  load-use hazard detected in ID.
- imem_ready  in  1  instruction memory accepts a fetch this cycle.
- npc_in  in  XLEN  NPC result for the current npc_op.
- npc_op  out  3  NPCOp to NPC, encoded with the NPC_* defines.
- pc_we  out  1  PC register load enable.
- pc_src_pend  out  1  PC mux selects pc_pend instead of the NPC output.
- pc_pend  out  XLEN  latched redirect target.
- j_fetch  out  1  refetch current PC (NPC PLUS4 path yields PC).
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  insert bubble in IF/ID.
- id_ex_flush  out  1  insert bubble in ID/EX.
- ex_mem_flush  out  1  insert bubble in EX/MEM.
- busy  out  1  state != RUN.

Behaviour:
- redirect = mem_valid & (mem_jal | mem_jalr | (mem_branch & mem_zero)).
- npc_op is combinational, in priority order: mem_jalr → NPC_JALR; mem_jal → NPC_JUMP; mem_branch → NPC_BRANCH; otherwise NPC_PLUS4.
- npc_op is forced to NPC_PLUS4 in PEND and whenever mem_valid=0.
- States are RUN, WAIT, PEND; the state register is the only FSM storage besides pc_pend.
- Reset (rst=1 at a clock edge): state←RUN, pc_pend←0.
- While rst=1, outputs are pc_we=0, all three flushes=1, if_id_stall=0, j_fetch=0, pc_src_pend=0, busy=0.
- RUN, priority top-down:
  - redirect & imem_ready: pc_we=1; if_id/id_ex/ex_mem flush=1; stay RUN. Same-cycle load-use is ignored.
  - redirect & !imem_ready: pc_we=0; pc_pend←npc_in; all three flushes=1; →PEND.
  - id_load_use: pc_we=0, j_fetch=1, if_id_stall=1, id_ex_flush=1; stay RUN, including when imem_ready=0.
  - !imem_ready: pc_we=0, j_fetch=1, if_id_flush=1; →WAIT.
  - otherwise: pc_we=1, npc_op=NPC_PLUS4.
- WAIT:
  - pc_we=0, j_fetch=1, if_id_flush=1.
  - id_load_use additionally asserts if_id_stall=1 and id_ex_flush=1; if_id_stall overrides if_id_flush.
  - redirect: latch pc_pend, all flushes=1, →PEND. This holds regardless of imem_ready, because the fetch is mid-flight.
  - imem_ready & !redirect: pc_we=1, →RUN.
- PEND:
  - pc_src_pend=1, if_id_flush=1, mem_* inputs ignored.
  - imem_ready: pc_we=1 (PC←pc_pend), →RUN.
  - !imem_ready: pc_we=0; remain indefinitely.
- Flush and stall asserted together on the same register: stall wins.
- Latency: a redirect reaches the PC on the same clock edge if imem_ready=1; otherwise one edge after imem_ready rises.

Optional Feature:
- Macro: PC_FLOW_PERF_CNT_EN.
- With the macro, add outputs stall_cnt, redirect_cnt, wait_cnt (CNT_W each). They count cycles with id_load_use honored, redirects accepted, and cycles in WAIT/PEND respectively.
- Counters saturate at all-ones and clear on rst.
- Without the macro, these ports and registers are absent.

Decomposition:
- Shared package/defines file: NPC_* encodings (already in ctrl_encode_def), plus new PCF_RUN/PCF_WAIT/PCF_PEND state encodings (2 bits).
- Natural sub-module: pc_flow_perf (the saturating counter trio), instantiated only under PC_FLOW_PERF_CNT_EN.

Test Plan:
- rst=1 for 2 cycles → pc_we=0, all flushes=1; after release with imem_ready=1 and no hazards → pc_we=1, npc_op=NPC_PLUS4, busy=0.
- mem_valid=1, mem_branch=1, mem_zero=1, imem_ready=1 → npc_op=NPC_BRANCH, pc_we=1, 3 flushes=1 for exactly 1 cycle; with mem_zero=0 → NPC_BRANCH, no flushes.
- mem_jalr=1, imem_ready=0, npc_in=0x0000_0040 → PEND, pc_pend=0x40. Hold imem_ready=0 for 3 cycles → pc_we=0, pc_src_pend=1. Raise imem_ready → pc_we=1, next state RUN.
- id_load_use=1 for 1 cycle → pc_we=0, j_fetch=1, if_id_stall=1, id_ex_flush=1; next cycle → normal PLUS4.
- imem_ready=0 for 2 cycles then redirect (mem_jal) in WAIT → PEND with pc_pend=npc_in. Simultaneous id_load_use+redirect in RUN → redirect wins, if_id_stall=0.
- With PC_FLOW_PERF_CNT_EN and CNT_W=4: 20 consecutive load-use cycles → stall_cnt=15 (saturated).
